i2c_eeprom_slave: RTL

Synthesizable, parametrised I2C slave that models a byte-addressed EEPROM, replacing ad-hoc bench-side read/write responders. It sits on the shared SCL/SDA bus opposite `i2c_master_top`. It supports single and multi-byte writes with page wrap, current-address read, random read via repeated START, and sequential read. All logic runs on the system clock; SCL and SDA are oversampled, never used as clocks.

---
 rtl/i2c_eeprom_slave_pkg.sv | 15 +
 rtl/i2c_eeprom_slave_bus_sync.sv | 51 +++++
 rtl/i2c_eeprom_slave.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_eeprom_slave_pkg.sv
// Shared FSM state encodings and bus-level constants for the I2C EEPROM slave.
package i2c_eeprom_slave_pkg;

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;

  localparam logic [7:0] MEM_INIT = 8'hff;

endpackage

// File: rtl/i2c_eeprom_slave_bus_sync.sv
// SCL/SDA synchronizers plus edge register; events are registered pulses, SYNC_STAGES+1 clk after the pin.
// START/STOP are judged with the current SCL level so a coincident SCL edge never masks them.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_c;
  logic                   sda_c;

  assign scl_c = scl_q[SYNC_STAGES-1];
  assign sda_c = sda_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q     <= '1;
      sda_q     <= '1;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_q     <= {scl_q[SYNC_STAGES-2:0], scl_i};
      sda_q     <= {sda_q[SYNC_STAGES-2:0], sda_i};
      scl_d     <= scl_c;
      sda_d     <= sda_c;
      scl_rise  <= scl_c & ~scl_d;
      scl_fall  <= ~scl_c & scl_d;
      start_det <= scl_c & sda_d & ~sda_c;
      stop_det  <= scl_c & ~sda_d & sda_c;
      sda_s     <= sda_c;
    end
  end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// Byte-addressed EEPROM model on an oversampled I2C bus; sda_oe moves SYNC_STAGES+2 clk after SCL falls.
// Optional write protect via I2C_EEPROM_SLAVE_WP_EN adds the wp port; bus flow control is ACK/NACK only.
module i2c_eeprom_slave
  import i2c_eeprom_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         ADDR_BYTES  = 2,
  parameter int         MEM_DEPTH   = 256,
  parameter int         PAGE_SIZE   = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
`ifdef I2C_EEPROM_SLAVE_WP_EN
  input  logic wp,
`endif
  output logic sda_oe,
  output logic wr_strb,
  output logic rd_strb,
  output logic busy
);

  localparam int            AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0] PG_MASK = AW'(PAGE_SIZE - 1);
  localparam logic [1:0]    LAST_AB = 2'(ADDR_BYTES - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [6:0]    sh, sh_nxt;
  logic [6:0]    tx, tx_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [1:0]    abyte, abyte_nxt;
  logic          addr_got, addr_got_nxt;
  logic          rw, rw_nxt;
  logic          oe_nxt, busy_nxt, wr_nxt, rd_nxt, mem_we;
  logic [7:0]    byte_in, rd_dat;
  logic          wp_on;

  logic [7:0] mem [MEM_DEPTH] = '{default: MEM_INIT};

`ifdef I2C_EEPROM_SLAVE_WP_EN
  assign wp_on = wp;
`else
  assign wp_on = 1'b0;
`endif

  assign byte_in = {sh, sda_s};
  assign rd_dat  = mem[ptr];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sh_nxt       = sh;
    tx_nxt       = tx;
    ptr_nxt      = ptr;
    abyte_nxt    = abyte;
    addr_got_nxt = addr_got;
    rw_nxt       = rw;
    oe_nxt       = sda_oe;
    busy_nxt     = busy;
    wr_nxt       = 1'b0;
    rd_nxt       = 1'b0;
    mem_we       = 1'b0;

    if (stop_det) begin
      state_nxt    = IDLE;
      oe_nxt       = 1'b0;
      busy_nxt     = 1'b0;
      cnt_nxt      = '0;
      addr_got_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt = DEV;
      oe_nxt    = 1'b0;
      cnt_nxt   = '0;
      if (state == IDLE) addr_got_nxt = 1'b0;
    end else begin
      unique case (state)
        DEV: if (scl_rise) begin
          sh_nxt  = byte_in[6:0];
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_nxt = DEV_ACK;
              rw_nxt    = byte_in[0];
              busy_nxt  = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        // sda_oe doubles as the ACK phase marker: first fall drives, second fall ends the ACK clock
        DEV_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            oe_nxt = ~I2C_ACK;
          end else if (rw == I2C_RD) begin
            state_nxt = RDATA;
            tx_nxt    = rd_dat[6:0];
            oe_nxt    = ~rd_dat[7];
            ptr_nxt   = ptr + 1'b1;
            rd_nxt    = 1'b1;
          end else begin
            oe_nxt    = 1'b0;
            abyte_nxt = '0;
            state_nxt = addr_got ? WDATA : WADDR;
          end
        end
        WADDR: if (scl_rise) begin
          sh_nxt  = byte_in[6:0];
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) begin
            ptr_nxt   = AW'({ptr, byte_in});
            abyte_nxt = abyte + 2'd1;
            state_nxt = WADDR_ACK;
            if (abyte == LAST_AB) addr_got_nxt = 1'b1;
          end
        end
        WADDR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            oe_nxt = ~I2C_ACK;
          end else begin
            oe_nxt    = 1'b0;
            state_nxt = addr_got ? WDATA : WADDR;
          end
        end
        WDATA: if (scl_rise) begin
          sh_nxt  = byte_in[6:0];
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (wp_on) begin
              state_nxt = IDLE;
            end else begin
              mem_we    = 1'b1;
              wr_nxt    = 1'b1;
              ptr_nxt   = (ptr & ~PG_MASK) | ((ptr + 1'b1) & PG_MASK);
              state_nxt = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_nxt = cnt + 3'd1;
            if (cnt == 3'd7) state_nxt = RACK;
          end else if (scl_fall) begin
            oe_nxt = ~tx[6];
            tx_nxt = {tx[5:0], 1'b1};
          end
        end
        // cnt marks whether the master's ACK has been sampled in this bit slot
        RACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) begin
              state_nxt = IDLE;
              oe_nxt    = 1'b0;
            end else begin
              cnt_nxt = 3'd1;
            end
          end else if (scl_fall) begin
            if (cnt == 3'd0) begin
              oe_nxt = 1'b0;
            end else begin
              state_nxt = RDATA;
              cnt_nxt   = '0;
              tx_nxt    = rd_dat[6:0];
              oe_nxt    = ~rd_dat[7];
              ptr_nxt   = ptr + 1'b1;
              rd_nxt    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      tx       <= '0;
      ptr      <= '0;
      abyte    <= '0;
      addr_got <= 1'b0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_strb  <= 1'b0;
      rd_strb  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sh       <= sh_nxt;
      tx       <= tx_nxt;
      ptr      <= ptr_nxt;
      abyte    <= abyte_nxt;
      addr_got <= addr_got_nxt;
      rw       <= rw_nxt;
      sda_oe   <= oe_nxt;
      busy     <= busy_nxt;
      wr_strb  <= wr_nxt;
      rd_strb  <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[ptr] <= byte_in;
  end

endmodule
